alu_wb_stage: RTL and testbench

Result/flag register stage directly downstream of the 8-bit Gumnut ALU datapath. Captures each ALU result with its carry-out, updates the architectural Z and C flags in program order, and feeds the carry flag back to the ALU's carry input. Results bound for a general register are buffered in a small FIFO and presented to the register-file write port over a valid/ready handshake, decoupling ALU issue from write-back stalls.

---
 rtl/gumnut_pkg.sv | 14 +
 rtl/wb_fifo.sv | 71 +++++++
 rtl/alu_wb_stage.sv | 81 ++++++++
 tb/tb_alu_wb_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gumnut_pkg.sv
// rtl/gumnut_pkg.sv - shared Gumnut datapath widths and write-back entry type
package gumnut_pkg;

    localparam int REG_IDX_W = 3;
    localparam int DATA_W    = 8;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - generic DEPTH-entry synchronous FIFO with occupancy count
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointer wrap is the natural overflow
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU result/flag register stage with buffered register write-back
module alu_wb_stage
    import gumnut_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [DATA_W-1:0]      res_i,
    input  logic                   cout_i,
    input  logic [REG_IDX_W-1:0]   rd_i,
    input  logic                   wr_en_i,
    input  logic                   setflags_i,
    output logic                   carry_o,
    output logic                   zero_o,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic [REG_IDX_W-1:0]   wb_rd_o,
    output logic [DATA_W-1:0]      wb_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    logic      c_q, c_d;
    logic      z_q, z_d;
    logic      accept;
    logic      push;
    logic      pop;
    logic      full;
    logic      empty;
    wb_entry_t push_entry;
    wb_entry_t head_entry;

    // Stall everything when full so flag updates never overtake a blocked write
    assign ready_o    = !full;
    assign accept     = valid_i && ready_o;
    assign push       = accept && wr_en_i && (rd_i != '0);
    assign wb_valid_o = !empty;
    assign pop        = wb_valid_o && wb_ready_i;
    assign push_entry = '{rd: rd_i, data: res_i};
    assign wb_rd_o    = head_entry.rd;
    assign wb_data_o  = head_entry.data;
    assign carry_o    = c_q;
    assign zero_o     = z_q;

    always_comb begin
        c_d = c_q;
        z_d = z_q;
        if (accept && setflags_i) begin
            c_d = cout_i;
            z_d = (res_i == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WB_ENTRY_W)
    ) u_wb_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .count_o (count_o),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb/tb_alu_wb_stage.sv - self-checking bench for alu_wb_stage
module tb_alu_wb_stage;

    localparam int DEPTH = 2;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] res_i = '0;
    logic       cout_i = 1'b0;
    logic [2:0] rd_i = '0;
    logic       wr_en_i = 1'b0;
    logic       setflags_i = 1'b0;
    logic       carry_o;
    logic       zero_o;
    logic       wb_valid_o;
    logic       wb_ready_i = 1'b0;
    logic [2:0] wb_rd_o;
    logic [7:0] wb_data_o;
    logic [$clog2(DEPTH):0] count_o;

    int checks = 0;
    int failures = 0;

    logic [10:0] mq[$];
    logic        mc = 1'b0;
    logic        mz = 1'b0;

    always #5 clk_i = ~clk_i;

    alu_wb_stage #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .res_i      (res_i),
        .cout_i     (cout_i),
        .rd_i       (rd_i),
        .wr_en_i    (wr_en_i),
        .setflags_i (setflags_i),
        .carry_o    (carry_o),
        .zero_o     (zero_o),
        .wb_valid_o (wb_valid_o),
        .wb_ready_i (wb_ready_i),
        .wb_rd_o    (wb_rd_o),
        .wb_data_o  (wb_data_o),
        .count_o    (count_o)
    );

    task automatic step(input logic v, input logic [7:0] res, input logic cout,
                        input logic [2:0] rd, input logic wr, input logic sf, input logic wbr);
        logic acc;
        logic pp;
        valid_i    = v;
        res_i      = res;
        cout_i     = cout;
        rd_i       = rd;
        wr_en_i    = wr;
        setflags_i = sf;
        wb_ready_i = wbr;
        acc = v && (mq.size() < DEPTH);
        pp  = wbr && (mq.size() != 0);
        @(posedge clk_i);
        #1;
        if (pp) void'(mq.pop_front());
        if (acc && wr && rd != 3'd0) mq.push_back({rd, res});
        if (acc && sf) begin
            mc = cout;
            mz = (res == 8'h00);
        end
    endtask

    task automatic do_reset(input logic v, input logic wbr);
        rst_n_i    = 1'b0;
        valid_i    = v;
        wb_ready_i = wbr;
        res_i      = 8'h77;
        wr_en_i    = 1'b1;
        rd_i       = 3'd5;
        setflags_i = 1'b1;
        cout_i     = 1'b1;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        valid_i = 1'b0;
        wb_ready_i = 1'b0;
        mq.delete();
        mc = 1'b0;
        mz = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        step(0, 8'h00, 0, 0, 0, 0, 0);
        checks++;
        if ({ready_o, wb_valid_o, carry_o, zero_o} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags got rdy/vld/c/z=%b%b%b%b want 1000", ready_o, wb_valid_o, carry_o, zero_o);
        end
        checks++;
        if (count_o !== 0 || wb_rd_o !== 3'd0 || wb_data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_fifo got count=%0d rd=%0d data=%h want 0 0 00", count_o, wb_rd_o, wb_data_o);
        end
    endtask

    task automatic test_flags_push();
        step(1, 8'h00, 1, 3'd3, 1, 1, 0);
        checks++;
        if ({zero_o, carry_o, wb_valid_o} !== 3'b111 || wb_rd_o !== 3'd3 || wb_data_o !== 8'h00) begin
            failures++;
            $display("FAIL flags_push got z/c/v=%b%b%b rd=%0d data=%h want 111 3 00",
                     zero_o, carry_o, wb_valid_o, wb_rd_o, wb_data_o);
        end
        step(0, 8'h00, 0, 0, 0, 0, 1);
        checks++;
        if (count_o !== 0 || wb_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flags_drain got count=%0d vld=%b want 0 0", count_o, wb_valid_o);
        end
    endtask

    task automatic test_r0_filter();
        step(1, 8'h5A, 0, 3'd0, 1, 1, 0);
        checks++;
        if (count_o !== 0 || zero_o !== 1'b0 || carry_o !== 1'b0) begin
            failures++;
            $display("FAIL r0_filter got count=%0d z=%b c=%b want 0 0 0", count_o, zero_o, carry_o);
        end
    endtask

    task automatic test_full_stall();
        step(1, 8'h11, 0, 3'd1, 1, 0, 0);
        step(1, 8'h22, 0, 3'd2, 1, 0, 0);
        checks++;
        if (count_o !== 2 || ready_o !== 1'b0 || wb_rd_o !== 3'd1 || wb_data_o !== 8'h11) begin
            failures++;
            $display("FAIL full_state got count=%0d rdy=%b rd=%0d data=%h want 2 0 1 11",
                     count_o, ready_o, wb_rd_o, wb_data_o);
        end
        step(1, 8'h00, 1, 3'd4, 1, 1, 0);
        checks++;
        if (count_o !== 2 || carry_o !== 1'b0 || zero_o !== 1'b0 || wb_data_o !== 8'h11) begin
            failures++;
            $display("FAIL full_stall got count=%0d c=%b z=%b data=%h want 2 0 0 11",
                     count_o, carry_o, zero_o, wb_data_o);
        end
        step(0, 8'h00, 0, 0, 0, 0, 1);
        checks++;
        if (count_o !== 1 || wb_rd_o !== 3'd2 || wb_data_o !== 8'h22) begin
            failures++;
            $display("FAIL full_pop1 got count=%0d rd=%0d data=%h want 1 2 22", count_o, wb_rd_o, wb_data_o);
        end
        step(0, 8'h00, 0, 0, 0, 0, 1);
        checks++;
        if (count_o !== 0 || wb_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL full_pop2 got count=%0d vld=%b want 0 0", count_o, wb_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 8'h40, 0, 3'd7, 1, 0, 0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            logic [7:0] d;
            logic [2:0] r;
            d = 8'h44 + 8'(i);
            r = 3'((i % 7) + 1);
            step(1, d, 0, r, 1, 0, 1);
            checks++;
            if (count_o !== 1 || wb_valid_o !== 1'b1 || wb_rd_o !== r || wb_data_o !== d) begin
                failures++;
                $display("FAIL back_to_back[%0d] got count=%0d rd=%0d data=%h want 1 %0d %h",
                         i, count_o, wb_rd_o, wb_data_o, r, d);
            end
        end
        step(0, 8'h00, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        step(1, 8'h01, 1, 3'd1, 1, 1, 0);
        step(1, 8'h02, 1, 3'd2, 1, 1, 0);
        checks++;
        if (count_o !== 2 || carry_o !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got count=%0d c=%b want 2 1", count_o, carry_o);
        end
        do_reset(1'b1, 1'b1);
        checks++;
        if (count_o !== 0 || wb_valid_o !== 1'b0 || carry_o !== 1'b0 || zero_o !== 1'b0 ||
            ready_o !== 1'b1 || wb_data_o !== 8'h00 || wb_rd_o !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid got count=%0d vld=%b c=%b z=%b rdy=%b rd=%0d data=%h want 0 0 0 0 1 0 00",
                     count_o, wb_valid_o, carry_o, zero_o, ready_o, wb_rd_o, wb_data_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                 1'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom_range(0, 2) != 0));
            checks++;
            if (ready_o !== (mq.size() < DEPTH) || wb_valid_o !== (mq.size() != 0) ||
                count_o !== 2'(mq.size()) || carry_o !== mc || zero_o !== mz) begin
                failures++;
                $display("FAIL random[%0d] got rdy=%b vld=%b count=%0d c=%b z=%b want %b %b %0d %b %b",
                         i, ready_o, wb_valid_o, count_o, carry_o, zero_o,
                         mq.size() < DEPTH, mq.size() != 0, mq.size(), mc, mz);
            end
            if (mq.size() != 0) begin
                checks++;
                if ({wb_rd_o, wb_data_o} !== mq[0]) begin
                    failures++;
                    $display("FAIL random_head[%0d] got rd=%0d data=%h want rd=%0d data=%h",
                             i, wb_rd_o, wb_data_o, mq[0][10:8], mq[0][7:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_flags_push();
        test_r0_filter();
        test_full_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
